// File: rtl/ex_div_ctrl_pkg.sv
// rtl/ex_div_ctrl_pkg.sv - shared types and constants for the RV32M divide sequencer
package ex_div_ctrl_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    REM  = 2'd2,
    REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int          DIV_XLEN      = 32;
  localparam int          DIV_CNT_W     = 6;
  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/ex_div_ctrl_div_step.sv
// rtl/ex_div_ctrl_div_step.sv - one combinational radix-2 restoring divide step
module ex_div_ctrl_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_trial;

  // rem < divisor always holds, so the shifted value is < 2*divisor and the
  // signed difference fits in XLEN+1 bits.
  assign w_shifted = {i_rem, i_quo[XLEN-1]};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  assign o_rem     = w_trial[XLEN] ? w_shifted[XLEN-1:0] : w_trial[XLEN-1:0];
  assign o_quo     = {i_quo[XLEN-2:0], ~w_trial[XLEN]};

endmodule

// File: rtl/ex_div_ctrl.sv
// rtl/ex_div_ctrl.sv - execute-stage sequencer for DIV/DIVU/REM/REMU
// Holds the pipeline stall while iterating, then pulses done with a registered result.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
#(
  parameter int XLEN  = DIV_XLEN,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t       r_state;
  div_op_t          r_op;
  logic             r_a_neg;
  logic             r_b_neg;
  logic [XLEN-1:0]  r_abs_b;
  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic [XLEN-1:0]  r_result;

  div_op_t          w_op;
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [XLEN-1:0]  w_abs_a;
  logic [XLEN-1:0]  w_abs_b;
  logic             w_div0;
  logic             w_ovf;
  logic             w_sel_quo;
  logic [XLEN-1:0]  w_special;
  logic [XLEN-1:0]  w_rem_n;
  logic [XLEN-1:0]  w_quo_n;
  logic [XLEN-1:0]  w_q_fix;
  logic [XLEN-1:0]  w_r_fix;
  logic [XLEN-1:0]  w_final;

  assign w_op      = div_op_t'(op);
  assign w_signed  = (w_op == DIV) || (w_op == REM);
  assign w_a_neg   = w_signed && a_in[XLEN-1];
  assign w_b_neg   = w_signed && b_in[XLEN-1];
  assign w_abs_a   = w_a_neg ? -a_in : a_in;
  assign w_abs_b   = w_b_neg ? -b_in : b_in;
  assign w_div0    = (b_in == '0);
  assign w_ovf     = w_signed && (a_in == INT_MIN) && (b_in == DIV_BY_ZERO_Q);
  assign w_sel_quo = (w_op == DIV) || (w_op == DIVU);

  // Divide-by-zero takes precedence over signed overflow (b cannot be both).
  always_comb begin
    w_special = '0;
    if (w_div0) begin
      w_special = w_sel_quo ? DIV_BY_ZERO_Q : a_in;
    end else if (w_ovf) begin
      w_special = w_sel_quo ? INT_MIN : '0;
    end
  end

  ex_div_ctrl_div_step #(.XLEN(XLEN)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_abs_b),
    .o_rem     (w_rem_n),
    .o_quo     (w_quo_n)
  );

  // Sign fix-up on the final step's outputs; r_*_neg are already 0 for unsigned ops.
  assign w_q_fix = (r_a_neg ^ r_b_neg) ? -w_quo_n : w_quo_n;
  assign w_r_fix = r_a_neg ? -w_rem_n : w_rem_n;
  assign w_final = ((r_op == DIV) || (r_op == DIVU)) ? w_q_fix : w_r_fix;

  assign stall  = !rst && !flush &&
                  (((r_state == IDLE) && start) || (r_state == CALC));
  assign done   = r_done;
  assign result = r_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= DIV;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
      r_abs_b  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (flush) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_op    <= w_op;
              r_a_neg <= w_a_neg;
              r_b_neg <= w_b_neg;
              r_abs_b <= w_abs_b;
              if (w_div0 || w_ovf) begin
                r_result <= w_special;
                r_done   <= 1'b1;
                r_state  <= DONE;
              end else begin
                r_rem   <= '0;
                r_quo   <= w_abs_a;
                r_cnt   <= CNT_W'(XLEN - 1);
                r_state <= CALC;
              end
            end
          end
          CALC: begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) begin
              r_result <= w_final;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end
          end
          DONE: begin
            // Same instruction is still in EX here, so start is not looked at.
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_div_ctrl.sv
// tb/tb_ex_div_ctrl.sv - scoreboard bench for ex_div_ctrl
module tb_ex_div_ctrl;
  import ex_div_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int stall_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          at_cyc;
    int          stalls;
  } exp_t;

  exp_t sb[$];

  ex_div_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a_in   (a_in),
    .b_in   (b_in),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks value, timing and stall length.
  always @(negedge clk) begin
    if (rst || flush) begin
      stall_cnt = 0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with result %h at cycle %0d expected no done", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", 32'(cyc), 32'(e.at_cyc));
        check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
      end
      stall_cnt = 0;
    end else if (stall) begin
      stall_cnt++;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    @(posedge clk); #1;
    start = 1'b1; op = o; a_in = a; b_in = b;
    if (push) sb.push_back('{exp, cyc + lat, lat});
    @(posedge clk); #1;
    // Scramble inputs to prove they were captured at acceptance.
    start = 1'b0; op = ~o; a_in = 32'hDEAD_BEEF; b_in = 32'h0000_0001;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
  endtask

  task automatic watch_no_done(input string name, input int n);
    bit seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; flush = 1'b0; op = DIVU; a_in = 32'd100; b_in = 32'd7;
    @(negedge clk);
    check("stall_in_reset", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("reset_done", 32'(done), 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_result", result, 32'd0);

    issue(DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);               drain();
    issue(REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33, 1'b1);  drain();
    issue(DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, 1'b1);  drain();
    issue(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);           drain();
    issue(REMU, 32'd5, 32'd0, 32'd5, 1, 1'b1);                   drain();
    issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1); drain();
    issue(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b1);   drain();
    issue(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b1);  drain();
    issue(REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, 33, 1'b1);         drain();

    // Flush mid-CALC at T+10.
    issue(DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_cycle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("after_flush_stall", 32'(stall), 32'd0);
    watch_no_done("flush_no_done", 40);

    // Start together with flush is not accepted.
    @(posedge clk); #1 start = 1'b1; flush = 1'b1; op = DIVU; a_in = 32'd8; b_in = 32'd2;
    @(negedge clk);
    check("start_flush_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    watch_no_done("start_flush_no_done", 40);

    issue(DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b1);                  drain();

    // Back-to-back with start held high through the first op's DONE.
    begin
      int n = 0;
      @(posedge clk); #1;
      start = 1'b1; op = DIV; a_in = 32'd20; b_in = 32'd4;
      sb.push_back('{32'd5, cyc + 33, 33});
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("b2b_first_done_seen", 32'(done), 32'd1);
      @(posedge clk); #1;
      a_in = 32'd21; b_in = 32'hFFFF_FFFC;
      sb.push_back('{32'hFFFF_FFFB, cyc + 33, 33});
      @(posedge clk); #1 start = 1'b0;
      drain();
    end

    // Reset at T+5 of an op kills it and clears the outputs.
    issue(DIV, 32'd21, 32'hFFFF_FFFC, 32'd0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_cycle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", 32'(done), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);
    check("post_rst_result", result, 32'd0);
    watch_no_done("rst_no_done", 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
